// File: rtl/cram_pkg.sv
// Shared constants for the cellular-RAM handshake: cfg_rw codes, responder
// state encodings and the wait-injection LFSR seed.
package cram_pkg;

  localparam logic [1:0] CRAM_NOP   = 2'b00;
  localparam logic [1:0] CRAM_READ  = 2'b10;
  localparam logic [1:0] CRAM_WRITE = 2'b01;

  localparam logic [2:0] RSP_IDLE   = 3'd0;
  localparam logic [2:0] RSP_ACCESS = 3'd1;
  localparam logic [2:0] RSP_DONE   = 3'd2;
  localparam logic [2:0] RSP_STALL  = 3'd3;

  localparam logic [15:0] RSP_LFSR_SEED = 16'hACE1;

  // 2'b11 is illegal on the bus and behaves like a NOP.
  function automatic logic cram_is_req(input logic [1:0] rw);
    return (rw == CRAM_READ) || (rw == CRAM_WRITE);
  endfunction

endpackage

// File: rtl/cram_bram_bytelane.sv
// Single-port block RAM, 2^DEPTH_LOG2 x DATA_W, with independent active-high
// write enables for the low and high byte and a registered read.
module cram_bram_bytelane #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_W     = 16
)(
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] i_adr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_we_lo,
  input  logic                  i_we_hi,
  output logic [DATA_W-1:0]     o_rdata
);
  localparam int BW = DATA_W / 2;

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we_lo) r_mem[i_adr][BW-1:0]     <= i_wdata[BW-1:0];
    if (i_we_hi) r_mem[i_adr][DATA_W-1:BW] <= i_wdata[DATA_W-1:BW];
    r_q <= r_mem[i_adr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/cram_bram_responder.sv
// CRAM-compatible responder backed by on-chip block RAM.
// Define CRAM_RESP_WAIT_INJECT_EN to add LFSR-driven random STALL cycles.
module cram_bram_responder
  import cram_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] memcntrl_adr,
  input  logic [1:0]        memcntrl_cfg_rw,
  input  logic [DATA_W-1:0] memcntrl_data_in,
  input  logic              lb_i,
  input  logic              ub_i,
  input  logic              memcntrl_cfg_thx,
  output logic [DATA_W-1:0] memcntrl_data_out,
  output logic              memcntrl_cfg_busy,
  output logic              memcntrl_cfg_finish,
  output logic [2:0]        memcntrl_cfg_state
);
  localparam int BW    = DATA_W / 2;
  localparam int CNT_W = ($clog2(LATENCY) > 4) ? $clog2(LATENCY) : 4;

  logic [2:0]            r_state;
  logic                  r_busy, r_finish;
  logic [DATA_W-1:0]     r_dout;
  logic [DEPTH_LOG2-1:0] r_adr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_lb, r_ub, r_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last;

  logic                  w_stall_go;
  logic [CNT_W-1:0]      w_stall_len;
  logic                  w_commit, w_we_lo, w_we_hi;
  logic [DATA_W-1:0]     w_q;
  logic                  w_unused_adr;

  assign w_unused_adr = ^memcntrl_adr[ADDR_W-1:DEPTH_LOG2];

`ifdef CRAM_RESP_WAIT_INJECT_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= RSP_LFSR_SEED;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall_go  = (r_lfsr[1:0] == 2'b11);
  assign w_stall_len = CNT_W'(r_lfsr[5:2]);
`else
  assign w_stall_go  = 1'b0;
  assign w_stall_len = '0;
`endif

  // Commit is gated by rst_n so a reset on the commit edge drops the write.
  assign w_commit = rst_n &&
                    (((r_state == RSP_ACCESS) && r_last && !w_stall_go) ||
                     ((r_state == RSP_STALL) && (r_cnt == '0)));
  assign w_we_lo  = w_commit && r_wr && !r_lb;
  assign w_we_hi  = w_commit && r_wr && !r_ub;

  cram_bram_bytelane #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .i_adr   (r_adr),
    .i_wdata (r_wdata),
    .i_we_lo (w_we_lo),
    .i_we_hi (w_we_hi),
    .o_rdata (w_q)
  );

  // After the countdown one extra ACCESS cycle lets the registered read settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RSP_IDLE;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_dout   <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_lb     <= 1'b1;
      r_ub     <= 1'b1;
      r_wr     <= 1'b0;
    end else begin
      case (r_state)
        RSP_IDLE: begin
          if (cram_is_req(memcntrl_cfg_rw)) begin
            r_adr   <= memcntrl_adr[DEPTH_LOG2-1:0];
            r_wdata <= memcntrl_data_in;
            r_lb    <= lb_i;
            r_ub    <= ub_i;
            r_wr    <= (memcntrl_cfg_rw == CRAM_WRITE);
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RSP_ACCESS;
          end
        end
        RSP_ACCESS: begin
          if (r_last) begin
            r_last <= 1'b0;
            if (w_stall_go) begin
              r_cnt   <= w_stall_len;
              r_state <= RSP_STALL;
            end else begin
              r_finish <= 1'b1;
              r_state  <= RSP_DONE;
            end
          end else if (r_cnt == '0) begin
            r_last <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RSP_STALL: begin
          if (r_cnt == '0) begin
            r_finish <= 1'b1;
            r_state  <= RSP_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RSP_DONE: begin
          if (memcntrl_cfg_thx) begin
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_state  <= RSP_IDLE;
          end
        end
        default: begin
          r_busy   <= 1'b0;
          r_finish <= 1'b0;
          r_state  <= RSP_IDLE;
        end
      endcase
      if (w_commit && !r_wr)
        r_dout <= {(r_ub ? {BW{1'b0}} : w_q[DATA_W-1:BW]),
                   (r_lb ? {BW{1'b0}} : w_q[BW-1:0])};
    end
  end

  assign memcntrl_data_out   = r_dout;
  assign memcntrl_cfg_busy   = r_busy;
  assign memcntrl_cfg_finish = r_finish;
  assign memcntrl_cfg_state  = r_state;

endmodule

// File: tb/tb_cram_bram_responder.sv
// Scoreboard bench for cram_bram_responder: driver pushes model-predicted
// read data per request, a finish-edge monitor pops and compares.
module tb_cram_bram_responder;
  import cram_pkg::*;

  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int DL  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [1:0]    rw = CRAM_NOP;
  logic [DW-1:0] din = '0;
  logic          lb = 1'b1, ub = 1'b1, thx = 1'b0;
  logic [DW-1:0] dout;
  logic          busy, fin;
  logic [2:0]    st;

  cram_bram_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .memcntrl_adr        (adr),
    .memcntrl_cfg_rw     (rw),
    .memcntrl_data_in    (din),
    .lb_i                (lb),
    .ub_i                (ub),
    .memcntrl_cfg_thx    (thx),
    .memcntrl_data_out   (dout),
    .memcntrl_cfg_busy   (busy),
    .memcntrl_cfg_finish (fin),
    .memcntrl_cfg_state  (st)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            req_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] mdl_mem [16];
  logic [DW-1:0] mdl_dout = '0;
  logic [DW-1:0] obs_data = '0;
  logic          prev_fin = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rising finish must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fin && !prev_fin) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_finish", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(dout), 32'(e.data));
`ifdef CRAM_RESP_WAIT_INJECT_EN
        chk("latency_range", 32'((cyc - e.req_cyc) >= LAT + 1 && (cyc - e.req_cyc) <= LAT + 17), 32'd1);
`else
        chk("latency", 32'(cyc - e.req_cyc), 32'(LAT + 1));
`endif
      end
      obs_data <= dout;
    end
    prev_fin <= fin;
  end

  task automatic op(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic l, input logic u, input int thx_dly, input bit hold_chk);
    int n;
    exp_t e;
    logic [DW-1:0] d0;
    logic [3:0] idx;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin chk("idle_timeout", 32'(busy), 32'd0); return; end
    rw = o; adr = a; din = d; lb = l; ub = u; thx = 1'b0;
    @(negedge clk);
    idx = a[3:0];
    if (o == CRAM_WRITE) begin
      if (!l) mdl_mem[idx][7:0]  = d[7:0];
      if (!u) mdl_mem[idx][15:8] = d[15:8];
    end else begin
      mdl_dout = {(u ? 8'h00 : mdl_mem[idx][15:8]), (l ? 8'h00 : mdl_mem[idx][7:0])};
    end
    e.data = mdl_dout;
    e.req_cyc = cyc;
    exp_q.push_back(e);
    n = 0;
    // Junk on cfg_rw/thx while busy must be ignored.
    while (!fin && n < 100) begin
      rw  = 2'($urandom_range(0, 3));
      thx = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    rw = CRAM_NOP;
    thx = 1'b0;
    if (!fin) begin chk("finish_timeout", 32'(fin), 32'd1); return; end
    d0 = dout;
    repeat (thx_dly) begin
      @(negedge clk);
      if (hold_chk) begin
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_finish", 32'(fin), 32'd1);
        chk("hold_data", 32'(dout), 32'(d0));
      end
    end
    thx = 1'b1;
    @(negedge clk);
    thx = 1'b0;
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_finish", 32'(fin), 32'd0);
    chk("release_state", 32'(st), 32'(RSP_IDLE));
  endtask

  task automatic wr32(input logic [AW-1:0] wa, input logic [31:0] d, input logic [3:0] m);
    op(CRAM_WRITE, wa,     d[15:0],  m[0], m[1], 0, 1'b0);
    op(CRAM_WRITE, wa + 1, d[31:16], m[2], m[3], 0, 1'b0);
  endtask

  task automatic rd32(input logic [AW-1:0] wa, output logic [31:0] q);
    op(CRAM_READ, wa, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    q[15:0] = obs_data;
    op(CRAM_READ, wa + 1, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    q[31:16] = obs_data;
  endtask

  initial begin
    logic [31:0] q32;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(fin), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_state", 32'(st), 32'(RSP_IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) op(CRAM_WRITE, AW'(i), 16'h0000, 1'b0, 1'b0, 0, 1'b0);

    op(CRAM_WRITE, 23'd5, 16'h12A5, 1'b0, 1'b1, 0, 1'b0);
    op(CRAM_READ,  23'd5, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    chk("lb_only_write", 32'(obs_data), 32'h00A5);

    op(CRAM_WRITE, 23'd7, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0);
    op(CRAM_WRITE, 23'd7, 16'h3400, 1'b1, 1'b0, 2, 1'b0);
    op(CRAM_READ,  23'd7, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    chk("ub_only_write", 32'(obs_data), 32'h34EF);

    op(CRAM_WRITE, 23'h10, 16'h5A5A, 1'b0, 1'b0, 0, 1'b0);
    op(CRAM_READ,  23'h0,  16'h0000, 1'b0, 1'b0, 0, 1'b0);
    chk("addr_wrap", 32'(obs_data), 32'h5A5A);
    op(CRAM_READ,  23'h7FFFF0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    chk("addr_wrap_hi_lane", 32'(obs_data), 32'h5A00);

    op(CRAM_READ, 23'd7, 16'h0000, 1'b0, 1'b0, 20, 1'b1);

    @(negedge clk);
    rw = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("illegal_busy", 32'(busy), 32'd0);
      chk("illegal_state", 32'(st), 32'(RSP_IDLE));
    end
    rw = CRAM_NOP;

    // Reset in the middle of a write: the write must be lost.
    op(CRAM_WRITE, 23'd3, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rw = CRAM_WRITE; adr = 23'd3; din = 16'hFFFF; lb = 1'b0; ub = 1'b0;
    @(negedge clk);
    rw = CRAM_NOP;
    @(negedge clk);
    chk("pre_reset_state", 32'(st), 32'(RSP_ACCESS));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_state", 32'(st), 32'(RSP_IDLE));
    chk("midop_rst_data", 32'(dout), 32'd0);
    mdl_dout = '0;
    op(CRAM_READ, 23'd3, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    chk("dropped_write", 32'(obs_data), 32'h0001);

    wr32(23'h200, 32'hDEADBEEF, 4'b0000);
    rd32(23'h200, q32);
    chk("wr32_full", q32, 32'hDEADBEEF);
    wr32(23'h200, 32'h00AA0000, 4'b1101);
    rd32(23'h200, q32);
    chk("wr32_masked", q32, 32'hDEAD00EF);

    for (int i = 0; i < 60; i++)
      op($urandom_range(0, 1) ? CRAM_READ : CRAM_WRITE, AW'($urandom), DW'($urandom),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
